// File: rtl/multiplier_pkg.sv
// State encoding shared by the Montgomery conversion and multiplier stages.
package multiplier_pkg;
    typedef enum logic [1:0] {
        TM_IDLE  = 2'd0,
        TM_SHIFT = 2'd1,
        TM_DONE  = 2'd2
    } tomont_state_e;
endpackage

// File: rtl/params_pkg.sv
// Shared modulus constants for the Montgomery datapath (Dilithium q by default).
package params_pkg;
    localparam int DATA_LENGTH = 64;
    localparam logic [DATA_LENGTH-1:0] MODULUS = 64'h0000_0000_007F_E001;
    localparam int MODULUS_LENGTH = 23;
endpackage

// File: rtl/mod_double_step.sv
// Combinational modular doubling: dbl = (2*acc) mod m, valid for acc < m.
module mod_double_step #(
    parameter int DATA_LENGTH = params_pkg::DATA_LENGTH
) (
    input  logic [DATA_LENGTH-1:0] acc,
    input  logic [DATA_LENGTH-1:0] m,
    output logic [DATA_LENGTH-1:0] dbl
);
    logic [DATA_LENGTH:0]   t;
    logic [DATA_LENGTH-1:0] t_low;
    logic                   ge;

    // Compare at full width; the subtract can wrap at DATA_LENGTH bits since the result is < m.
    always_comb begin
        t     = {acc, 1'b0};
        t_low = {acc[DATA_LENGTH-2:0], 1'b0};
        ge    = (t >= {1'b0, m});
        dbl   = ge ? (t_low - m) : t_low;
    end
endmodule

// File: rtl/montgomery_to_mont.sv
// Serial conversion y -> y*2^m_bl mod m, one modular doubling per clock.
// Optional input range checking with error_o is enabled by defining TOMONT_RANGE_CHK_EN.
module montgomery_to_mont
    import multiplier_pkg::*;
#(
    parameter int DATA_LENGTH = params_pkg::DATA_LENGTH
) (
    input  logic                   CLK_pci_sys_clk_p,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [DATA_LENGTH-1:0] y_i,
    input  logic [DATA_LENGTH-1:0] m_i,
    input  logic [DATA_LENGTH-1:0] m_bl_i,
    output logic                   busy_o,
    output logic [DATA_LENGTH-1:0] result_o,
    output logic                   valid_o
`ifdef TOMONT_RANGE_CHK_EN
    ,
    output logic                   error_o
`endif
);
    localparam int CNT_W = $clog2(DATA_LENGTH + 1);

    tomont_state_e          state_reg, state_next;
    logic [DATA_LENGTH-1:0] acc_reg, acc_next;
    logic [DATA_LENGTH-1:0] m_reg, m_next;
    logic [DATA_LENGTH-1:0] result_reg;
    logic [DATA_LENGTH-1:0] dbl;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic                   start_err;

    mod_double_step #(.DATA_LENGTH(DATA_LENGTH)) u_double (
        .acc (acc_reg),
        .m   (m_reg),
        .dbl (dbl)
    );

`ifdef TOMONT_RANGE_CHK_EN
    logic error_reg;
    assign start_err = (y_i >= m_i) || !m_i[0] || (m_bl_i > DATA_LENGTH'(DATA_LENGTH));
`else
    assign start_err = 1'b0;
`endif

    always_ff @(posedge CLK_pci_sys_clk_p or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= TM_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            TM_IDLE: begin
                if (start_i) begin
                    state_next = (start_err || (m_bl_i == '0)) ? TM_DONE : TM_SHIFT;
                end
            end
            TM_SHIFT: begin
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = TM_DONE;
                end
            end
            TM_DONE: state_next = TM_IDLE;
            default: state_next = TM_IDLE;
        endcase
    end

    always_comb begin
        acc_next = acc_reg;
        m_next   = m_reg;
        cnt_next = cnt_reg;
        case (state_reg)
            TM_IDLE: begin
                if (start_i) begin
                    acc_next = start_err ? '0 : y_i;
                    m_next   = m_i;
                    cnt_next = m_bl_i[CNT_W-1:0];
                end
            end
            TM_SHIFT: begin
                acc_next = dbl;
                cnt_next = cnt_reg - CNT_W'(1);
            end
            default: ;
        endcase
    end

    // The result is loaded on the edge entering DONE so it is valid together with valid_o.
    always_ff @(posedge CLK_pci_sys_clk_p or posedge rst_i) begin
        if (rst_i) begin
            acc_reg    <= '0;
            m_reg      <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
        end else begin
            acc_reg <= acc_next;
            m_reg   <= m_next;
            cnt_reg <= cnt_next;
            if (state_next == TM_DONE) begin
                result_reg <= acc_next;
            end
        end
    end

`ifdef TOMONT_RANGE_CHK_EN
    // Errors only arise at start, so a DONE entered from SHIFT always clears the flag.
    always_ff @(posedge CLK_pci_sys_clk_p or posedge rst_i) begin
        if (rst_i) begin
            error_reg <= 1'b0;
        end else if (state_next == TM_DONE) begin
            error_reg <= (state_reg == TM_IDLE) && start_err;
        end
    end
`endif

    always_comb begin
        busy_o   = (state_reg != TM_IDLE);
        valid_o  = (state_reg == TM_DONE);
        result_o = result_reg;
`ifdef TOMONT_RANGE_CHK_EN
        error_o  = error_reg;
`endif
    end
endmodule
